// File: rtl/branch_prediction_unit.sv
// Fetch-stage direction predictor: a PC-indexed table of 2-bit counters chooses the next fetch PC.
// A redirect from branch resolution flushes the fetch register, and the resolved branch trains the table.
module branch_prediction_unit #(
  parameter int          IDX_BITS = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      pc,
  output logic [31:0]      inst_out,
  output logic [31:0]      pc_out,
  output logic             pre_target_enable,
  input  logic             upd_valid,
  input  logic [31:0]      upd_inst,
  input  logic [31:0]      upd_pc,
  input  logic             true_taken,
  input  logic             target_enable,
  input  logic [31:0]      target,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int NENT = 1 << IDX_BITS;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [31:0] pc_q, pc_d, inst_q, inst_d, pco_q, pco_d;
  logic        pte_q, pte_d;
  logic [NENT-1:0][1:0] bht_q, bht_d;
  logic [CNT_W-1:0] bc_q, bc_d, mc_q, mc_d;

  logic [5:0]          f_op, u_op;
  logic                f_cond, f_jmp, pred_taken, redirect, train;
  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [15:0]         imm;
  logic [31:0]         br_tgt, j_tgt, pred_tgt;

  assign f_op   = imem_inst[31:26];
  assign u_op   = upd_inst[31:26];
  assign f_cond = (f_op == OP_BEQ) || (f_op == OP_BNE);
  assign f_jmp  = (f_op == OP_J);
  assign f_idx  = pc_q[IDX_BITS+1:2];
  assign u_idx  = upd_pc[IDX_BITS+1:2];

  // Target arithmetic matches the ALU so a correct prediction never triggers a redirect.
  assign imm      = imem_inst[15:0];
  assign br_tgt   = pc_q + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_tgt    = {pc_q[31:28], imem_inst[25:0], 2'b00};
  assign pred_tgt = f_jmp ? j_tgt : br_tgt;

  // Lookup reads bht_q, so a same-cycle update of this entry is seen only next cycle.
  assign pred_taken = f_jmp | (f_cond & bht_q[f_idx][1]);
  assign redirect   = upd_valid & target_enable;
  assign train      = upd_valid & ((u_op == OP_BEQ) || (u_op == OP_BNE));

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    pco_d  = pco_q;
    pte_d  = pte_q;
    if (redirect) begin
      pc_d   = target;
      inst_d = 32'd0;
      pco_d  = 32'd0;
      pte_d  = 1'b0;
    end else if (!stall) begin
      pc_d   = pred_taken ? pred_tgt : pc_q + 32'd4;
      inst_d = imem_inst;
      pco_d  = pc_q;
      pte_d  = pred_taken;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (train) begin
      if (true_taken && bht_q[u_idx] != 2'b11)
        bht_d[u_idx] = bht_q[u_idx] + 2'b01;
      else if (!true_taken && bht_q[u_idx] != 2'b00)
        bht_d[u_idx] = bht_q[u_idx] - 2'b01;
    end
  end

  always_comb begin
    bc_d = bc_q;
    mc_d = mc_q;
    if (train && !(&bc_q))    bc_d = bc_q + 1'b1;
    if (redirect && !(&mc_q)) mc_d = mc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      inst_q <= 32'd0;
      pco_q  <= 32'd0;
      pte_q  <= 1'b0;
      bht_q  <= {NENT{2'b01}};
      bc_q   <= '0;
      mc_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      pco_q  <= pco_d;
      pte_q  <= pte_d;
      bht_q  <= bht_d;
      bc_q   <= bc_d;
      mc_q   <= mc_d;
    end
  end

  assign pc                = pc_q;
  assign inst_out          = inst_q;
  assign pc_out            = pco_q;
  assign pre_target_enable = pte_q;
  assign branch_count      = bc_q;
  assign mispredict_count  = mc_q;

  logic unused_bits;
  assign unused_bits = ^{upd_inst[25:0], upd_pc};
endmodule

// File: tb/tb_branch_prediction_unit.sv
// Directed bench for branch_prediction_unit: a cycle table plus hand sequences for saturation,
// same-cycle lookup/update ordering and asynchronous reset.
module tb_branch_prediction_unit;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP  = 32'h20010001;
  localparam logic [31:0] JMP  = 32'h08000010;
  localparam logic [31:0] BEQM = 32'h1000FFFE;  // beq, imm = -2
  localparam logic [31:0] BEQS = 32'h1000FFFF;  // beq, imm = -1 (targets itself)
  localparam logic [31:0] BNE3 = 32'h14000003;

  logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
  logic [31:0] imem_inst = NOP, upd_inst = NOP, upd_pc = 32'd0, target = 32'd0;
  logic upd_valid = 1'b0, true_taken = 1'b0, target_enable = 1'b0;
  logic [31:0] pc, inst_out, pc_out;
  logic pre_target_enable;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  int checks = 0, errors = 0;

  branch_prediction_unit #(.IDX_BITS(4), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_inst(imem_inst), .pc(pc),
    .inst_out(inst_out), .pc_out(pc_out), .pre_target_enable(pre_target_enable),
    .upd_valid(upd_valid), .upd_inst(upd_inst), .upd_pc(upd_pc), .true_taken(true_taken),
    .target_enable(target_enable), .target(target), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [31:0] inst;
    logic        uv;
    logic [31:0] uinst, upc;
    logic        tt, te;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_inst, e_pco;
    logic        e_pte;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [31:0] inst, input logic uv,
                     input logic [31:0] uinst, input logic [31:0] upc, input logic tt,
                     input logic te, input logic [31:0] tgt, input logic [31:0] e_pc,
                     input logic [31:0] e_inst, input logic [31:0] e_pco, input logic e_pte);
    vec_t v;
    v.stall = st; v.inst = inst; v.uv = uv; v.uinst = uinst; v.upc = upc; v.tt = tt;
    v.te = te; v.tgt = tgt; v.e_pc = e_pc; v.e_inst = e_inst; v.e_pco = e_pco; v.e_pte = e_pte;
    vq.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic cyc(input logic st, input logic [31:0] inst, input logic uv,
                     input logic [31:0] uinst, input logic [31:0] upc, input logic tt,
                     input logic te, input logic [31:0] tgt);
    stall = st; imem_inst = inst; upd_valid = uv; upd_inst = uinst; upd_pc = upc;
    true_taken = tt; target_enable = te; target = tgt;
    @(posedge clk); #1;
  endtask

  initial begin
    // stall inst uv uinst upc tt te tgt | pc inst_out pc_out pte
    add(0, NOP,  0, NOP,  0,      0, 0, 0,            32'h4,        NOP,  32'h0,        0);
    add(0, NOP,  0, NOP,  0,      0, 0, 0,            32'h8,        NOP,  32'h4,        0);
    add(1, NOP,  0, NOP,  0,      0, 0, 0,            32'h8,        NOP,  32'h4,        0);
    add(0, NOP,  1, NOP,  0,      0, 1, 32'h40,       32'h40,       0,    0,            0);
    add(0, JMP,  0, NOP,  0,      0, 0, 0,            32'h40,       JMP,  32'h40,       1);
    add(0, NOP,  0, NOP,  0,      0, 0, 0,            32'h44,       NOP,  32'h40,       0);
    add(0, NOP,  1, NOP,  0,      0, 1, 32'h100,      32'h100,      0,    0,            0);
    add(0, BEQM, 0, NOP,  0,      0, 0, 0,            32'h104,      BEQM, 32'h100,      0);
    add(0, NOP,  1, BEQM, 32'h100, 1, 0, 0,           32'h108,      NOP,  32'h104,      0);
    add(0, NOP,  1, BEQM, 32'h100, 1, 0, 0,           32'h10C,      NOP,  32'h108,      0);
    add(0, NOP,  1, NOP,  0,      0, 1, 32'h100,      32'h100,      0,    0,            0);
    add(0, BEQM, 0, NOP,  0,      0, 0, 0,            32'hFC,       BEQM, 32'h100,      1);
    add(1, NOP,  1, NOP,  0,      0, 1, 32'h200,      32'h200,      0,    0,            0);
    add(0, BNE3, 0, NOP,  0,      0, 0, 0,            32'h210,      BNE3, 32'h200,      1);
    add(0, NOP,  1, NOP,  0,      0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0,    0,            0);
    add(0, NOP,  0, NOP,  0,      0, 0, 0,            32'h0,        NOP,  32'hFFFFFFFC, 0);
    add(0, NOP,  1, NOP,  0,      0, 1, 32'hA0000000, 32'hA0000000, 0,    0,            0);
    add(0, JMP,  0, NOP,  0,      0, 0, 0,            32'hA0000040, JMP,  32'hA0000000, 1);

    @(posedge clk); @(posedge clk); #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_inst", inst_out, 32'h0);
    chk("reset_pco", pc_out, 32'h0);
    chk("reset_pte", {31'd0, pre_target_enable}, 32'h0);
    chk("reset_bc", {28'd0, branch_count}, 32'h0);
    reset = 1'b0;
    #1;

    foreach (vq[i]) begin
      cyc(vq[i].stall, vq[i].inst, vq[i].uv, vq[i].uinst, vq[i].upc, vq[i].tt, vq[i].te, vq[i].tgt);
      chk($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
      chk($sformatf("v%0d_inst", i), inst_out, vq[i].e_inst);
      chk($sformatf("v%0d_pco", i), pc_out, vq[i].e_pco);
      chk($sformatf("v%0d_pte", i), {31'd0, pre_target_enable}, {31'd0, vq[i].e_pte});
    end
    chk("tbl_bc", {28'd0, branch_count}, 32'd2);
    chk("tbl_mc", {28'd0, mispredict_count}, 32'd6);

    // Five not-taken trainings on entry 1; a self-targeting beq probes the counter each time.
    for (int k = 0; k < 5; k++) begin
      cyc(0, NOP, 1, BEQS, 32'h104, 0, 1, 32'h104);
      cyc(0, BEQS, 0, NOP, 0, 0, 0, 0);
      chk($sformatf("sat%0d_pte", k), {31'd0, pre_target_enable}, 32'd0);
      chk($sformatf("sat%0d_pc", k), pc, 32'h108);
    end
    // Counter at 00: train taken (->01), then fetch while training taken again (->10).
    cyc(0, NOP, 1, BEQS, 32'h104, 1, 1, 32'h104);
    cyc(0, BEQS, 1, BEQS, 32'h104, 1, 0, 0);
    chk("same_cyc_pte", {31'd0, pre_target_enable}, 32'd0);
    chk("same_cyc_pc", pc, 32'h108);
    cyc(0, NOP, 1, NOP, 0, 0, 1, 32'h104);
    cyc(0, BEQS, 0, NOP, 0, 0, 0, 0);
    chk("next_cyc_pte", {31'd0, pre_target_enable}, 32'd1);
    chk("next_cyc_pc", pc, 32'h104);
    chk("mid_bc", {28'd0, branch_count}, 32'd9);
    chk("mid_mc", {28'd0, mispredict_count}, 32'd13);

    for (int k = 0; k < 4; k++) cyc(0, NOP, 1, NOP, 0, 0, 1, 32'h300);
    chk("mc_sat", {28'd0, mispredict_count}, 32'd15);
    chk("bc_hold", {28'd0, branch_count}, 32'd9);

    // Asynchronous reset while stalled, between clock edges.
    cyc(1, NOP, 0, NOP, 0, 0, 0, 0);
    chk("pre_areset_pc", pc, 32'h300);
    #2 reset = 1'b1;
    #1;
    chk("areset_stall_pc", pc, 32'h0);
    chk("areset_stall_mc", {28'd0, mispredict_count}, 32'd0);
    chk("areset_stall_bc", {28'd0, branch_count}, 32'd0);
    @(negedge clk) reset = 1'b0;
    // Asynchronous reset with a redirect pending.
    cyc(0, NOP, 1, BEQM, 32'h0, 1, 1, 32'h500);
    chk("pre_areset2_pc", pc, 32'h500);
    cyc(0, NOP, 1, NOP, 0, 0, 1, 32'h600);
    #2 reset = 1'b1;
    #1;
    chk("areset_redir_pc", pc, 32'h0);
    chk("areset_redir_inst", inst_out, 32'h0);
    chk("areset_redir_mc", {28'd0, mispredict_count}, 32'd0);
    @(posedge clk); #1;
    chk("areset_held_pc", pc, 32'h0);
    @(negedge clk);
    reset = 1'b0; upd_valid = 1'b0; target_enable = 1'b0; imem_inst = BEQM;
    @(posedge clk); #1;
    chk("post_reset_pte", {31'd0, pre_target_enable}, 32'd0);
    chk("post_reset_pc", pc, 32'h4);
    cyc(0, NOP, 1, BEQM, 32'h0, 1, 1, 32'h0);
    cyc(0, BEQM, 0, NOP, 0, 0, 0, 0);
    chk("post_train_pte", {31'd0, pre_target_enable}, 32'd1);
    chk("post_train_pc", pc, 32'hFFFFFFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_prediction_unit.md
Name: branch_prediction_unit

Overview:
Front-end fetch/prediction stage that produces the fetch PC and the predicted-direction bit consumed by the ALU branch-resolution logic. It is the other end of the ALU resolution interface: it emits pre_target_enable, and it absorbs target_enable, target, mod_pc, mod_inst and true_taken as a redirect and training port. Direction prediction uses a PC-indexed table of 2-bit saturating counters. Taken targets are computed from the fetched instruction word, so no BTB is needed.

Parameters:
IDX_BITS, 4, BHT index width; the table holds 2^IDX_BITS counters indexed by pc[IDX_BITS+1:2]
RESET_PC, 32'h00000000, fetch PC after reset
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hold fetch state and output registers
imem_inst  input  32  instruction word at pc, combinational from instruction memory
pc  output  32  current fetch address to instruction memory
inst_out  output  32  fetched instruction passed down the pipe
pc_out  output  32  address of inst_out
pre_target_enable  output  1  predicted-taken bit travelling with inst_out
upd_valid  input  1  one-cycle strobe: the ALU resolution fields below are valid
upd_inst  input  32  resolved instruction (mod_inst)
upd_pc  input  32  resolved instruction address (mod_pc)
true_taken  input  1  resolved direction
target_enable  input  1  mispredict, which requests a redirect
target  input  32  correct next PC on mispredict
branch_count  output  CNT_W  resolved conditional branches
mispredict_count  output  CNT_W  redirects taken

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC.
  - inst_out = 0 (NOP).
  - pc_out = 0.
  - pre_target_enable = 0.
  - Every BHT counter = 2'b01 (weakly not-taken).
  - Both performance counters = 0.
  - Reset asserted mid-operation abandons any pending redirect or update.
- Opcode decode on imem_inst[31:26]:
  - 000100 beq and 000101 bne are conditional.
  - 000010 j is unconditional.
  - All other opcodes are non-branch.
- Prediction is combinational on the current fetch:
  - Conditional: taken iff BHT[pc[IDX_BITS+1:2]][1] == 1.
  - j: always taken.
  - Non-branch: not taken.
- Predicted target must match the ALU arithmetic exactly:
  - j: {pc[31:28], imem_inst[25:0], 2'b00}.
  - beq/bne: pc + 4 + ({{14{imm[15]}}, imm, 2'b00}), computed modulo 2^32.
- Next-PC priority at each rising clk (first match wins):
  1. upd_valid && target_enable: pc <= target; inst_out <= 0, pc_out <= 0, pre_target_enable <= 0 (flush the wrong-path fetch). Redirect overrides stall.
  2. stall: pc, inst_out, pc_out and pre_target_enable all hold.
  3. Predicted taken: pc <= predicted target.
  4. Otherwise: pc <= pc + 4, wrapping at 2^32.
- In cases 3 and 4: inst_out <= imem_inst, pc_out <= pc, pre_target_enable <= the prediction. Latency is 1 cycle from fetch to outputs.
- BHT training:
  - Occurs when upd_valid and upd_inst[31:26] is beq or bne. It is independent of stall.
  - Index is upd_pc[IDX_BITS+1:2].
  - true_taken=1 increments with saturation at 2'b11; true_taken=0 decrements with saturation at 2'b00.
  - j and non-branch updates leave the table unchanged.
- Same-cycle lookup and update of the same entry: the lookup uses the pre-update value; the new value is visible from the next cycle.
- Performance counters:
  - branch_count increments on each training event.
  - mispredict_count increments on each redirect.
  - Both saturate at all-ones and never wrap.
- upd_valid=0: target_enable, target and true_taken are ignored.

Test Plan:
1. Reset then free-run with non-branch instructions (imem_inst=32'h20010001) -> pc sequence RESET_PC, +4, +8; pre_target_enable=0; inst_out lags imem_inst by 1 cycle.
2. j with imem_inst=32'h08000010 at pc=32'h00000040 -> next pc=32'h00000040 (target {0,26'h10,00}); pre_target_enable=1 on the following cycle.
3. beq at pc=0x100, imm=0xFFFE, counter 01 -> predicted not-taken, next pc=0x104. Two updates with upd_valid=1, true_taken=1, upd_pc=0x100 -> counter 11. Refetch 0x100 -> next pc=0xFC, pre_target_enable=1.
4. Mispredict redirect: upd_valid=1, target_enable=1, target=0x200, issued while stall=1 -> next pc=0x200; inst_out=0; pre_target_enable=0; mispredict_count +1.
5. Saturation: five not-taken updates to one entry -> counter stays 00. Taken update and fetch of the same index in one cycle -> that fetch predicts not-taken, the next fetch uses counter 01.
6. Assert reset asynchronously mid-stall, mid-redirect -> pc=RESET_PC and outputs zero immediately without a clock edge; BHT reads 01 afterwards.
